// File: rtl/synchro_pkg.sv
// Shared constants for the button conditioner and the synchro_register stage.
// Debounce lengths are in CLK cycles: short for simulation, 10 ms at 100 MHz for the board.
package synchro_pkg;

  localparam int DEBOUNCE_SIM = 4;
  localparam int DEBOUNCE_HW  = 1_000_000;

endpackage : synchro_pkg

// File: rtl/debounce_channel.sv
// One button: two-flop synchronizer followed by a symmetric debounce filter.
// ST follows the synchronized level only after it has differed from ST for DEBOUNCE_CYCLES cycles.
module debounce_channel
  import synchro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RAW,
  output logic ST
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so sync1 -> sync2 forms a real two-stage shift.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= RAW;
      sync2 <= sync1;
    end
  end

  // Any cycle where sync2 agrees with ST throws away the partial count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ST  <= 1'b0;
      cnt <= '0;
    end else if (sync2 == ST) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      ST  <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Turns the two raw ZEROES/ONES buttons into clean, mutually exclusive command levels
// plus single-cycle press strobes for synchro_register.
module button_conditioner
  import synchro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_ZEROES_RAW,
  input  logic BTN_ONES_RAW,
  output logic ZEROES,
  output logic ONES,
  output logic ZEROES_PULSE,
  output logic ONES_PULSE,
  output logic CONFLICT
);

  logic st_z;
  logic st_o;
  logic zprev;
  logic oprev;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_zeroes (
    .CLK  (CLK),
    .RESET(RESET),
    .RAW  (BTN_ZEROES_RAW),
    .ST   (st_z)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ones (
    .CLK  (CLK),
    .RESET(RESET),
    .RAW  (BTN_ONES_RAW),
    .ST   (st_o)
  );

  // Both held means neither command is issued; the register stage must never see both.
  assign CONFLICT = st_z & st_o;
  assign ZEROES   = st_z & ~st_o;
  assign ONES     = st_o & ~st_z;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      zprev <= 1'b0;
      oprev <= 1'b0;
    end else begin
      zprev <= ZEROES;
      oprev <= ONES;
    end
  end

  // Strobes are taken on the arbitrated level, so a conflict ending also yields a pulse.
  assign ZEROES_PULSE = ZEROES & ~zprev;
  assign ONES_PULSE   = ONES & ~oprev;

endmodule : button_conditioner

// File: doc/button_conditioner.md
# button_conditioner

Conditions two raw push-button inputs into the clean ZEROES/ONES command levels consumed by synchro_register. Each button gets a two-flop synchronizer and a debounce counter. Simultaneous presses are arbitrated. Single-cycle press pulses are emitted for logic that needs edge events. It sits between the board pins and the register stage, in the CLK domain.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized level must persist before it is accepted. Must be ≥ 1. Simulation uses 4; hardware uses 1_000_000 (10 ms at 100 MHz).
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; never overridden.
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- BTN_ZEROES_RAW  in  1  raw, asynchronous, bouncing button for the clear command.
- BTN_ONES_RAW  in  1  raw, asynchronous, bouncing button for the set command.
- ZEROES  out  1  debounced, arbitrated clear level; drives synchro_register ZEROES.
- ONES  out  1  debounced, arbitrated set level; drives synchro_register ONES.
- ZEROES_PULSE  out  1  one-cycle strobe on each rising edge of ZEROES.
- ONES_PULSE  out  1  one-cycle strobe on each rising edge of ONES.
- CONFLICT  out  1  both debounced levels are high.

## Operation
- Per channel:
  - raw → sync1 → sync2 (two flops).
  - Debounced state `st` with counter `cnt`.
  - sync2 == st: cnt ← 0.
  - sync2 != st and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - sync2 != st and cnt == DEBOUNCE_CYCLES-1: st ← sync2, cnt ← 0.
- Debouncing is symmetric: release is filtered exactly like press.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never changes st. Any return of sync2 to st restarts the count from 0.
- Arbitration:
  - CONFLICT = st_z & st_o.
  - ZEROES = st_z & ~st_o; ONES = st_o & ~st_z.
  - ZEROES and ONES are never high together.
- Pulses:
  - Registered previous values zprev/oprev.
  - ZEROES_PULSE = ZEROES & ~zprev; ONES_PULSE likewise.
  - When a conflict ends with one button still held, the surviving output rises and its pulse fires.
- Reset:
  - All flops (sync, st, cnt, prev) clear asynchronously, so all outputs are 0 while RESET is high.
  - Reset asserted mid-count discards progress.
  - After release, a held button needs the full latency again.

## Timing
- Latency from raw edge to ZEROES/ONES, raw stable before edge 1:
  - sync2 updates at edge 2.
  - st updates at edge 2+DEBOUNCE_CYCLES (edge 6 for the default).
- Outputs are combinational from st, so they follow in the same cycle; no extra stage.
- Pulse is high during the cycle after the edge where st rises, and low on the next edge.
- Press and release have identical latency.
- Both buttons are processed independently and in parallel. If both become valid on the same edge, CONFLICT rises on that edge with no pulses.
- No handshake; the downstream stage samples levels every cycle.

## Structure
- Shared package `synchro_pkg`:
  - DEBOUNCE_SIM = 4 and DEBOUNCE_HW = 1_000_000 constants.
  - No other types needed.
- One natural sub-module, `debounce_channel` (parameter DEBOUNCE_CYCLES; ports CLK, RESET, RAW, ST), instantiated twice.
- The top level holds arbitration, prev flops and pulse logic.

## Test plan
- **Reset:** RESET=1 for 5 cycles with both buttons high → all outputs 0. After release, ONES stays 0 until edge 6 post-release.
- **Clean press:** BTN_ONES_RAW 0→1, held 10 cycles → ONES=1 after edge 6. ONES_PULSE high exactly one cycle. ZEROES=0, CONFLICT=0 throughout.
- **Bounce:** BTN_ZEROES_RAW toggles 1,0,1,0 at 1-cycle spacing, then holds 1 → ZEROES rises 6 edges after the final 0→1 transition. Exactly one ZEROES_PULSE.
- **Short glitch:** BTN_ONES_RAW high for 3 cycles only → ONES, ONES_PULSE stay 0.
- **Conflict:** ONES debounced high, then ZEROES pressed → CONFLICT=1, and ZEROES=ONES=0 from edge 6 after the ZEROES press. Release ONES → after 6 edges, CONFLICT=0, ZEROES=1, one ZEROES_PULSE.
- **Reset mid-count:** assert RESET at count 2 of a press → outputs stay 0. On release with the button still held, the output rises exactly 6 edges later.
